alu_mul_seq: RTL and testbench

//  Iterative shift-add multiplier controller that drives the 64-bit combinational ALU.
//  - Each iteration issues one ALU ADD (accumulator + shifted multiplicand).
//  - Produces the low XLEN bits of A*B, which is RV64 MUL semantics (same for signed and unsigned).
//  - Sits in EX beside the ALU; owns the ALU operand/op inputs while busy.

---
 rtl/alu_mul_seq_pkg.sv | 16 +
 rtl/alu_mul_seq_if.sv | 26 ++
 rtl/alu_mul_seq.sv | 81 ++++++++
 tb/tb_alu_mul_seq.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/alu_mul_seq_pkg.sv
// Shared definitions for the shift-add multiplier controller: ALU opcodes and FSM encoding.
package alu_mul_seq_pkg;

  localparam logic [3:0] ALUOP_AND = 4'b0000;
  localparam logic [3:0] ALUOP_OR  = 4'b0001;
  localparam logic [3:0] ALUOP_ADD = 4'b0010;
  localparam logic [3:0] ALUOP_SUB = 4'b0110;
  localparam logic [3:0] ALUOP_SLT = 4'b0111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/alu_mul_seq_if.sv
// Request/response and ALU-drive signals of the multiplier controller, bundled for the EX stage.
interface alu_mul_seq_if #(
    parameter int XLEN = 64
);
    logic            start;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] product;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;

    // The parent (issuer plus the ALU beside the controller) is the master.
    modport master (
        output start, a, b, alu_result,
        input  busy, done, product, alu_a, alu_b, alu_op
    );

    modport slave (
        input  start, a, b, alu_result,
        output busy, done, product, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_mul_seq.sv
// Iterative shift-add multiplier: one ALU ADD per iteration, yields the low XLEN bits of a*b.
module alu_mul_seq
    import alu_mul_seq_pkg::*;
#(
    parameter int XLEN       = 64,
    parameter bit EARLY_EXIT = 1'b1
) (
    input logic          clk,
    input logic          rst,
    alu_mul_seq_if.slave bus
);

    localparam int              CNT_W    = $clog2(XLEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(XLEN - 1);

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic [XLEN-1:0]   acc;
    logic [XLEN-1:0]   mcand;
    logic [XLEN-1:0]   mplier;
    logic [CNT_W-1:0]  cnt;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // NOTE: defaults first so no path through the case leaves a signal unassigned (no latches).
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (bus.start) begin
                    accept    = 1'b1;
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                // Early exit looks at the multiplier as it will be after this shift.
                if ((cnt == CNT_LAST) || (EARLY_EXIT && (mplier[XLEN-1:1] == '0)))
                    state_nxt = S_DONE;
            end
            S_DONE: begin
                accept    = bus.start;
                state_nxt = bus.start ? S_RUN : S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // NOTE: datapath registers are few and must read 0 after reset, so all of them are reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            cnt    <= '0;
        end else if (accept) begin
            acc    <= '0;
            mcand  <= bus.a;
            mplier <= bus.b;
            cnt    <= '0;
        end else if (state == S_RUN) begin
            if (mplier[0]) acc <= bus.alu_result;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
        end
    end

    assign bus.busy    = (state == S_RUN);
    assign bus.done    = (state == S_DONE);
    assign bus.product = acc;
    assign bus.alu_a   = acc;
    assign bus.alu_b   = mcand;
    assign bus.alu_op  = ALUOP_ADD;

endmodule

// File: tb/tb_alu_mul_seq.sv
// Bench for alu_mul_seq: one instance per EARLY_EXIT setting, each beside a behavioural ALU.
module tb_alu_mul_seq;
    import alu_mul_seq_pkg::*;

    localparam int XLEN    = 64;
    localparam int TIMEOUT = 200;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_mul_seq_if #(.XLEN(XLEN)) if_full  ();
    alu_mul_seq_if #(.XLEN(XLEN)) if_early ();

    alu_mul_seq #(.XLEN(XLEN), .EARLY_EXIT(1'b0)) u_full  (.clk(clk), .rst(rst), .bus(if_full.slave));
    alu_mul_seq #(.XLEN(XLEN), .EARLY_EXIT(1'b1)) u_early (.clk(clk), .rst(rst), .bus(if_early.slave));

    function automatic logic [XLEN-1:0] alu_model(input logic [3:0] op, input logic [XLEN-1:0] x,
                                                  input logic [XLEN-1:0] y);
        case (op)
            ALUOP_AND: return x & y;
            ALUOP_OR:  return x | y;
            ALUOP_ADD: return x + y;
            ALUOP_SUB: return x - y;
            ALUOP_SLT: return {{(XLEN-1){1'b0}}, ($signed(x) < $signed(y))};
            default:   return '0;
        endcase
    endfunction

    assign if_full.alu_result  = alu_model(if_full.alu_op, if_full.alu_a, if_full.alu_b);
    assign if_early.alu_result = alu_model(if_early.alu_op, if_early.alu_a, if_early.alu_b);

    // Stimulus is shared; sel routes start to one instance and picks which outputs are observed.
    logic            sel = 1'b0;
    logic            start_v = 1'b0;
    logic [XLEN-1:0] a_v = '0;
    logic [XLEN-1:0] b_v = '0;

    assign if_full.start  = start_v & ~sel;
    assign if_early.start = start_v & sel;
    assign if_full.a  = a_v;
    assign if_full.b  = b_v;
    assign if_early.a = a_v;
    assign if_early.b = b_v;

    wire            busy_o    = sel ? if_early.busy    : if_full.busy;
    wire            done_o    = sel ? if_early.done    : if_full.done;
    wire [XLEN-1:0] product_o = sel ? if_early.product : if_full.product;
    wire [XLEN-1:0] alu_a_o   = sel ? if_early.alu_a   : if_full.alu_a;
    wire [XLEN-1:0] alu_b_o   = sel ? if_early.alu_b   : if_full.alu_b;
    wire [3:0]      alu_op_o  = sel ? if_early.alu_op  : if_full.alu_op;

    int n_checks = 0;
    int n_fails  = 0;

    task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Caller sits 1 time unit after an edge. Returns product and RUN-edge count.
    task automatic run_op(input bit ee, input logic [XLEN-1:0] av, input logic [XLEN-1:0] bv,
                          output logic [XLEN-1:0] prod, output int cyc);
        logic [XLEN-1:0] exp_acc;
        int k;
        sel = ee; a_v = av; b_v = bv; start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        exp_acc = '0;
        k   = 0;
        cyc = 0;
        do begin
            check("run_busy", {63'd0, busy_o}, 64'd1);
            check("alu_op", {60'd0, alu_op_o}, {60'd0, ALUOP_ADD});
            check("alu_a_acc", alu_a_o, exp_acc);
            check("alu_b_shift", alu_b_o, av << k);
            @(posedge clk); #1;
            if (k < XLEN && bv[k]) exp_acc = exp_acc + (av << k);
            k++;
            cyc++;
        end while (!done_o && cyc < TIMEOUT);
        if (!done_o) check("done_timeout", 64'(cyc), 64'(TIMEOUT + 1));
        prod = product_o;
        check("done_not_busy", {63'd0, busy_o}, 64'd0);
        check("product_model", product_o, exp_acc);
        @(posedge clk); #1;
        check("done_one_cycle", {63'd0, done_o}, 64'd0);
        check("product_held", product_o, prod);
    endtask

    typedef struct {
        bit              ee;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [XLEN-1:0] exp_prod;
        int              exp_cyc;
    } vec_t;

    vec_t vecs[10];

    initial begin
        logic [XLEN-1:0] prod;
        int cyc;

        vecs[0] = '{1'b0, 64'd123, 64'd456, 64'd56088, 64};
        vecs[1] = '{1'b0, -64'sd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFF1, 64};
        vecs[2] = '{1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64};
        vecs[3] = '{1'b0, 64'h1_0000_0000, 64'h1_0000_0000, 64'd0, 64};
        vecs[4] = '{1'b1, 64'd123, 64'd0, 64'd0, 1};
        vecs[5] = '{1'b1, 64'h1234, 64'h8, 64'h91A0, 4};
        vecs[6] = '{1'b1, -64'sd5, 64'd3, 64'hFFFF_FFFF_FFFF_FFF1, 2};
        vecs[7] = '{1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64};
        vecs[8] = '{1'b1, 64'd7, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 64};
        vecs[9] = '{1'b1, 64'd12345, 64'd1, 64'd12345, 1};

        // Reset state
        #12;
        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            check("rst_busy", {63'd0, busy_o}, 64'd0);
            check("rst_done", {63'd0, done_o}, 64'd0);
            check("rst_product", product_o, 64'd0);
            check("rst_alu_b", alu_b_o, 64'd0);
            check("rst_alu_op", {60'd0, alu_op_o}, {60'd0, ALUOP_ADD});
        end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Table-driven vectors
        foreach (vecs[i]) begin
            run_op(vecs[i].ee, vecs[i].a, vecs[i].b, prod, cyc);
            check($sformatf("vec%0d_product", i), prod, vecs[i].exp_prod);
            check($sformatf("vec%0d_cycles", i), 64'(cyc), 64'(vecs[i].exp_cyc));
        end

        // Start held high, operands changed mid-run, back-to-back restart from DONE
        sel = 1'b1; a_v = 64'd10; b_v = 64'd5; start_v = 1'b1;
        @(posedge clk); #1;
        check("b2b_busy_e0", {63'd0, busy_o}, 64'd1);
        a_v = 64'd3; b_v = 64'd2;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("b2b_busy_e2", {63'd0, busy_o}, 64'd1);
        @(posedge clk); #1;
        check("b2b_done_e3", {63'd0, done_o}, 64'd1);
        check("b2b_first_product", product_o, 64'd50);
        @(posedge clk); #1;
        check("b2b_no_idle_gap", {63'd0, busy_o}, 64'd1);
        check("b2b_done_dropped", {63'd0, done_o}, 64'd0);
        start_v = 1'b0;
        cyc = 0;
        while (!done_o && cyc < TIMEOUT) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("b2b_second_cycles", 64'(cyc), 64'd2);
        check("b2b_second_product", product_o, 64'd6);
        @(posedge clk); #1;

        // Asynchronous reset mid-run, then start presented in the deassert cycle
        sel = 1'b0; a_v = 64'd9; b_v = 64'd9; start_v = 1'b1;
        @(posedge clk); #1;
        start_v = 1'b0;
        repeat (10) begin
            @(posedge clk); #1;
        end
        check("abort_busy_before", {63'd0, busy_o}, 64'd1);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", {63'd0, busy_o}, 64'd0);
        check("abort_done", {63'd0, done_o}, 64'd0);
        check("abort_product", product_o, 64'd0);
        @(posedge clk); #1;
        check("abort_no_done", {63'd0, done_o}, 64'd0);
        rst = 1'b0;
        run_op(1'b0, 64'd6, 64'd7, prod, cyc);
        check("post_rst_product", prod, 64'd42);
        check("post_rst_cycles", 64'(cyc), 64'd64);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
